reservation_station: RTL and testbench

// - Parametrised reservation station for the OOO core. Holds up to RS_SIZE dispatched ops.
// - Captures operands broadcast on NUM_CDB common-data-bus channels.
// - Issues the oldest fully-ready op to one execution unit via a valid/ready handshake.
// - Sits between the dispatch/rename stage and an execution unit. Replaces the fixed 2-entry debug RS in core.

---
 rtl/ooo_pkg.sv | 27 ++
 rtl/reservation_station_if.sv | 43 ++++
 rtl/reservation_station_age_matrix.sv | 44 ++++
 rtl/reservation_station.sv | 130 +++++++++++++
 tb/tb_reservation_station.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ooo_pkg.sv
// Shared out-of-order core types: operand/value widths, producer tags,
// and the reservation-station operand and entry records.
package ooo_pkg;
  localparam int REG_SIZE  = 64;
  localparam int GPR_COUNT = 32;
  localparam int ROB_SIZE  = 8;
  localparam int TAG_W     = $clog2(ROB_SIZE);
  localparam int OPCODE_W  = 4;

  typedef logic [TAG_W-1:0]    tag_t;
  typedef logic [REG_SIZE-1:0] reg_t;
  typedef logic [OPCODE_W-1:0] opc_t;

  typedef struct packed {
    logic valid;
    tag_t tag;
    reg_t value;
  } rs_op;

  typedef struct packed {
    logic busy;
    opc_t opcode;
    tag_t dst_tag;
    rs_op op1;
    rs_op op2;
  } rs_entry;
endpackage

// File: rtl/reservation_station_if.sv
// Dispatch, CDB, issue and occupancy bundle of the reservation station.
// slave = station side, master = dispatch/CDB/execution-unit side.
interface reservation_station_if
  import ooo_pkg::*;
#(
  parameter int NUM_CDB = 2,
  parameter int CNT_W   = 3
) ();
  logic                      i_disp_valid;
  logic                      o_disp_ready;
  opc_t                      i_disp_opcode;
  tag_t                      i_disp_dst_tag;
  rs_op                      i_disp_op1;
  rs_op                      i_disp_op2;
  logic [NUM_CDB-1:0]        i_cdb_valid;
  tag_t [NUM_CDB-1:0]        i_cdb_tag;
  reg_t [NUM_CDB-1:0]        i_cdb_value;
  logic                      o_issue_valid;
  logic                      i_issue_ready;
  opc_t                      o_issue_opcode;
  tag_t                      o_issue_dst_tag;
  reg_t                      o_issue_op1;
  reg_t                      o_issue_op2;
  logic [CNT_W-1:0]          o_count;

  modport slave (
    input  i_disp_valid, i_disp_opcode, i_disp_dst_tag,
    input  i_disp_op1, i_disp_op2,
    input  i_cdb_valid, i_cdb_tag, i_cdb_value,
    input  i_issue_ready,
    output o_disp_ready, o_issue_valid, o_issue_opcode,
    output o_issue_dst_tag, o_issue_op1, o_issue_op2, o_count
  );

  modport master (
    output i_disp_valid, i_disp_opcode, i_disp_dst_tag,
    output i_disp_op1, i_disp_op2,
    output i_cdb_valid, i_cdb_tag, i_cdb_value,
    output i_issue_ready,
    input  o_disp_ready, o_issue_valid, o_issue_opcode,
    input  o_issue_dst_tag, o_issue_op1, o_issue_op2, o_count
  );
endinterface

// File: rtl/reservation_station_age_matrix.sv
// rs_age_matrix: N x N dispatch-order bits; older[i][j]=1 => i before j.
// Ports: alloc/free one-hot, busy and ready vectors in; oldest-ready grant out.
module rs_age_matrix #(
  parameter int N = 4
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_flush,
  input  logic [N-1:0] i_alloc,
  input  logic [N-1:0] i_free,
  input  logic [N-1:0] i_busy,
  input  logic [N-1:0] i_ready,
  output logic [N-1:0] o_grant
);
  logic [N-1:0][N-1:0] older_q, older_d;

  always_comb begin
    older_d = older_q;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (i_alloc[j]) older_d[i][j] = i_busy[i];
        if (i_alloc[i]) older_d[i][j] = 1'b0;
        // an entry leaving the station has no age relation left
        if (i_free[i] || i_free[j]) older_d[i][j] = 1'b0;
      end
    end
    if (i_flush) older_d = '0;
  end

  always_comb begin
    o_grant = '0;
    for (int i = 0; i < N; i++) begin
      o_grant[i] = i_ready[i];
      for (int j = 0; j < N; j++) begin
        if (i_ready[j] && older_q[j][i]) o_grant[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) older_q <= '0;
    else         older_q <= older_d;
  end
endmodule

// File: rtl/reservation_station.sv
// Reservation station: holds dispatched ops, captures CDB operands, and
// issues the oldest ready op. Ports: clk/reset/flush plus the io bundle.
module reservation_station
  import ooo_pkg::*;
#(
  parameter int RS_SIZE = 4,
  parameter int NUM_CDB = 2
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_flush,
  reservation_station_if.slave   io
);
  localparam int CNT_W = $clog2(RS_SIZE + 1);

  rs_entry [RS_SIZE-1:0] ent_q, ent_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [RS_SIZE-1:0]    busy, ready, grant;
  logic [RS_SIZE-1:0]    alloc, alloc_fire, free_fire;
  logic                  disp_ready, disp_fire;
  logic                  issue_valid, issue_fire;
  logic                  found;
  rs_entry               sel;

  // lowest-index channel wins if several match the same tag
  function automatic rs_op wake(
    input rs_op               op,
    input logic [NUM_CDB-1:0] v,
    input tag_t [NUM_CDB-1:0] t,
    input reg_t [NUM_CDB-1:0] val
  );
    rs_op r;
    logic hit;
    r   = op;
    hit = 1'b0;
    for (int c = 0; c < NUM_CDB; c++) begin
      if (!op.valid && !hit && v[c] && t[c] == op.tag) begin
        r.valid = 1'b1;
        r.value = val[c];
        hit     = 1'b1;
      end
    end
    return r;
  endfunction

  always_comb begin
    alloc = '0;
    found = 1'b0;
    for (int i = 0; i < RS_SIZE; i++) begin
      busy[i]  = ent_q[i].busy;
      ready[i] = ent_q[i].busy && ent_q[i].op1.valid
                 && ent_q[i].op2.valid;
      if (!found && !ent_q[i].busy) begin
        alloc[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  assign disp_ready  = count_q < CNT_W'(RS_SIZE);
  assign disp_fire   = io.i_disp_valid && disp_ready && !i_flush;
  assign issue_valid = (|grant) && !i_flush;
  assign issue_fire  = issue_valid && io.i_issue_ready;
  assign alloc_fire  = alloc & {RS_SIZE{disp_fire}};
  assign free_fire   = grant & {RS_SIZE{issue_fire}};

  rs_age_matrix #(.N(RS_SIZE)) u_age (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_flush (i_flush),
    .i_alloc (alloc_fire),
    .i_free  (free_fire),
    .i_busy  (busy),
    .i_ready (ready),
    .o_grant (grant)
  );

  always_comb begin
    sel = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (grant[i]) sel = ent_q[i];
    end
  end

  assign io.o_disp_ready    = disp_ready;
  assign io.o_issue_valid   = issue_valid;
  assign io.o_issue_opcode  = sel.opcode;
  assign io.o_issue_dst_tag = sel.dst_tag;
  assign io.o_issue_op1     = sel.op1.value;
  assign io.o_issue_op2     = sel.op2.value;
  assign io.o_count         = count_q;

  always_comb begin
    ent_d = ent_q;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (ent_q[i].busy) begin
        ent_d[i].op1 = wake(ent_q[i].op1, io.i_cdb_valid,
                            io.i_cdb_tag, io.i_cdb_value);
        ent_d[i].op2 = wake(ent_q[i].op2, io.i_cdb_valid,
                            io.i_cdb_tag, io.i_cdb_value);
      end
      if (free_fire[i]) ent_d[i].busy = 1'b0;
      if (alloc_fire[i]) begin
        ent_d[i].busy    = 1'b1;
        ent_d[i].opcode  = io.i_disp_opcode;
        ent_d[i].dst_tag = io.i_disp_dst_tag;
        ent_d[i].op1     = wake(io.i_disp_op1, io.i_cdb_valid,
                                io.i_cdb_tag, io.i_cdb_value);
        ent_d[i].op2     = wake(io.i_disp_op2, io.i_cdb_valid,
                                io.i_cdb_tag, io.i_cdb_value);
      end
    end
    if (i_flush) ent_d = '0;
  end

  always_comb begin
    count_d = count_q + CNT_W'(disp_fire) - CNT_W'(issue_fire);
    if (i_flush) count_d = '0;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ent_q   <= '0;
      count_q <= '0;
    end else begin
      ent_q   <= ent_d;
      count_q <= count_d;
    end
  end
endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station (RS_SIZE=4, NUM_CDB=2):
// a vector table for single-op flows plus hand sequences for ordering/flush.
module tb_reservation_station;
  import ooo_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  reservation_station_if #(.NUM_CDB(2), .CNT_W(3)) bus ();

  reservation_station #(.RS_SIZE(4), .NUM_CDB(2)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .i_flush (flush),
    .io      (bus.slave)
  );

  always @(posedge clk) begin
    assert (!(bus.i_cdb_valid == 2'b11 &&
              bus.i_cdb_tag[0] == bus.i_cdb_tag[1]))
      else $error("illegal: two CDB channels carry the same tag");
  end

  typedef struct {
    logic        dv;
    logic [3:0]  opc;
    logic [2:0]  dst;
    rs_op        op1;
    rs_op        op2;
    logic [1:0]  cv;
    logic [2:0]  t0, t1;
    logic [63:0] v0, v1;
    logic        ir;
    logic [2:0]  e_cnt;
    logic        e_iv;
    logic        e_dr;
    logic [63:0] e_op1, e_op2;
    logic [2:0]  e_dst;
    logic [3:0]  e_opc;
  } vec_t;

  vec_t vecs[12];

  function automatic rs_op mk_op(input logic v, input logic [2:0] t,
                                 input logic [63:0] val);
    rs_op r;
    r.valid = v;
    r.tag   = t;
    r.value = val;
    return r;
  endfunction

  function automatic vec_t mk(
    input logic dv, input logic [3:0] opc, input logic [2:0] dst,
    input rs_op o1, input rs_op o2,
    input logic [1:0] cv, input logic [2:0] t0, input logic [63:0] v0,
    input logic [2:0] t1, input logic [63:0] v1,
    input logic [2:0] e_cnt, input logic e_iv,
    input logic [63:0] e_op1, input logic [63:0] e_op2,
    input logic [2:0] e_dst, input logic [3:0] e_opc);
    vec_t r;
    r.dv = dv; r.opc = opc; r.dst = dst; r.op1 = o1; r.op2 = o2;
    r.cv = cv; r.t0 = t0; r.v0 = v0; r.t1 = t1; r.v1 = v1;
    r.ir = 1'b1;
    r.e_cnt = e_cnt; r.e_iv = e_iv; r.e_dr = 1'b1;
    r.e_op1 = e_op1; r.e_op2 = e_op2; r.e_dst = e_dst; r.e_opc = e_opc;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    bus.i_disp_valid   = 1'b0;
    bus.i_disp_opcode  = '0;
    bus.i_disp_dst_tag = '0;
    bus.i_disp_op1     = '0;
    bus.i_disp_op2     = '0;
    bus.i_cdb_valid    = '0;
    bus.i_cdb_tag      = '0;
    bus.i_cdb_value    = '0;
  endtask

  task automatic disp(input logic [3:0] opc, input logic [2:0] dst,
                      input rs_op o1, input rs_op o2);
    bus.i_disp_valid   = 1'b1;
    bus.i_disp_opcode  = opc;
    bus.i_disp_dst_tag = dst;
    bus.i_disp_op1     = o1;
    bus.i_disp_op2     = o2;
  endtask

  task automatic cdb(input int ch, input logic [2:0] t,
                     input logic [63:0] v);
    bus.i_cdb_valid[ch] = 1'b1;
    bus.i_cdb_tag[ch]   = t;
    bus.i_cdb_value[ch] = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  rs_op nv;

  initial begin
    nv = mk_op(1'b0, 3'd0, 64'd0);
    //            dv opc dst op1                 op2
    //            cv t0 v0 t1 v1 | cnt iv op1 op2 dst opc
    vecs[0]  = mk(1, 1, 3, mk_op(1, 0, 5), mk_op(1, 0, 7),
                  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[1]  = mk(0, 0, 0, nv, nv,
                  0, 0, 0, 0, 0, 1, 1, 5, 7, 3, 1);
    vecs[2]  = mk(1, 2, 4, mk_op(0, 2, 0), mk_op(1, 0, 1),
                  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[3]  = mk(0, 0, 0, nv, nv,
                  2'b10, 0, 0, 2, 64'h1234, 1, 0, 0, 0, 0, 0);
    vecs[4]  = mk(0, 0, 0, nv, nv,
                  0, 0, 0, 0, 0, 1, 1, 64'h1234, 1, 4, 2);
    vecs[5]  = mk(1, 3, 5, mk_op(0, 6, 0), mk_op(1, 0, 2),
                  2'b01, 6, 9, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[6]  = mk(0, 0, 0, nv, nv,
                  0, 0, 0, 0, 0, 1, 1, 9, 2, 5, 3);
    vecs[7]  = mk(0, 0, 0, nv, nv,
                  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[8]  = mk(1, 4, 1, mk_op(1, 0, 10), mk_op(1, 0, 11),
                  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[9]  = mk(1, 5, 2, mk_op(1, 0, 12), mk_op(1, 0, 13),
                  0, 0, 0, 0, 0, 1, 1, 10, 11, 1, 4);
    vecs[10] = mk(0, 0, 0, nv, nv,
                  0, 0, 0, 0, 0, 1, 1, 12, 13, 2, 5);
    vecs[11] = mk(0, 0, 0, nv, nv,
                  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // reset with a dispatch held on the bus
    rst   = 1'b1;
    flush = 1'b0;
    idle();
    bus.i_issue_ready = 1'b1;
    disp(4'd9, 3'd7, mk_op(1, 0, 64'h55), mk_op(1, 0, 64'h66));
    tick();
    tick();
    rst = 1'b0;
    idle();
    #1;
    chk("reset count", 64'(bus.o_count), 64'd0);
    chk("reset disp_ready", 64'(bus.o_disp_ready), 64'd1);
    chk("reset issue_valid", 64'(bus.o_issue_valid), 64'd0);
    chk("reset issue_op1", bus.o_issue_op1, 64'd0);
    tick();

    for (int i = 0; i < 12; i++) begin
      idle();
      bus.i_issue_ready = vecs[i].ir;
      if (vecs[i].dv)
        disp(vecs[i].opc, vecs[i].dst, vecs[i].op1, vecs[i].op2);
      bus.i_cdb_valid    = vecs[i].cv;
      bus.i_cdb_tag[0]   = vecs[i].t0;
      bus.i_cdb_value[0] = vecs[i].v0;
      bus.i_cdb_tag[1]   = vecs[i].t1;
      bus.i_cdb_value[1] = vecs[i].v1;
      #1;
      chk($sformatf("v%0d count", i), 64'(bus.o_count),
          64'(vecs[i].e_cnt));
      chk($sformatf("v%0d issue_valid", i), 64'(bus.o_issue_valid),
          64'(vecs[i].e_iv));
      chk($sformatf("v%0d disp_ready", i), 64'(bus.o_disp_ready),
          64'(vecs[i].e_dr));
      if (vecs[i].e_iv) begin
        chk($sformatf("v%0d op1", i), bus.o_issue_op1, vecs[i].e_op1);
        chk($sformatf("v%0d op2", i), bus.o_issue_op2, vecs[i].e_op2);
        chk($sformatf("v%0d dst", i), 64'(bus.o_issue_dst_tag),
            64'(vecs[i].e_dst));
        chk($sformatf("v%0d opc", i), 64'(bus.o_issue_opcode),
            64'(vecs[i].e_opc));
      end
      tick();
    end

    // fill the station with waiting ops, then wake youngest before oldest
    idle();
    bus.i_issue_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      disp(4'(k), (k == 3) ? 3'd5 : 3'(k),
           mk_op(0, 3'(k + 1), 0), mk_op(1, 0, 64'(256 + k)));
      #1;
      chk($sformatf("fill%0d count", k), 64'(bus.o_count), 64'(k));
      tick();
    end
    disp(4'd8, 3'd7, mk_op(1, 0, 1), mk_op(1, 0, 2));
    #1;
    chk("full count", 64'(bus.o_count), 64'd4);
    chk("full disp_ready", 64'(bus.o_disp_ready), 64'd0);
    tick();
    idle();
    cdb(0, 3'd4, 64'h44);
    #1;
    chk("fifth dropped count", 64'(bus.o_count), 64'd4);
    chk("none ready", 64'(bus.o_issue_valid), 64'd0);
    tick();
    idle();
    cdb(1, 3'd1, 64'hAA);
    #1;
    chk("D only valid", 64'(bus.o_issue_valid), 64'd1);
    chk("D only dst", 64'(bus.o_issue_dst_tag), 64'd5);
    chk("D only op1", bus.o_issue_op1, 64'h44);
    tick();
    idle();
    bus.i_issue_ready = 1'b1;
    #1;
    chk("oldest valid", 64'(bus.o_issue_valid), 64'd1);
    chk("oldest A dst", 64'(bus.o_issue_dst_tag), 64'd0);
    chk("oldest A op1", bus.o_issue_op1, 64'hAA);
    chk("oldest A op2", bus.o_issue_op2, 64'h100);
    tick();
    #1;
    chk("then D dst", 64'(bus.o_issue_dst_tag), 64'd5);
    chk("then D valid", 64'(bus.o_issue_valid), 64'd1);
    tick();
    bus.i_issue_ready = 1'b0;
    #1;
    chk("after two issues count", 64'(bus.o_count), 64'd2);
    chk("after two issues valid", 64'(bus.o_issue_valid), 64'd0);

    // third entry is ready, then flush with a dispatch alongside
    disp(4'd6, 3'd6, mk_op(1, 0, 64'h77), mk_op(1, 0, 64'h78));
    tick();
    idle();
    #1;
    chk("pre-flush count", 64'(bus.o_count), 64'd3);
    chk("pre-flush valid", 64'(bus.o_issue_valid), 64'd1);
    chk("pre-flush dst", 64'(bus.o_issue_dst_tag), 64'd6);
    flush = 1'b1;
    bus.i_issue_ready = 1'b1;
    disp(4'd7, 3'd3, mk_op(1, 0, 1), mk_op(1, 0, 2));
    #1;
    chk("flush masks issue", 64'(bus.o_issue_valid), 64'd0);
    tick();
    flush = 1'b0;
    idle();
    #1;
    chk("post-flush count", 64'(bus.o_count), 64'd0);
    chk("post-flush valid", 64'(bus.o_issue_valid), 64'd0);
    chk("post-flush disp_ready", 64'(bus.o_disp_ready), 64'd1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule
